// File: rtl/arbitrate.sv
// N-to-1 arbitrating mux: merges N valid/ready streams into one registered stream tagged {sel, dat}.
// Define ARBITRATE_ROUND_ROBIN_EN for round-robin grant; otherwise fixed priority, lowest index wins.
module arbitrate #(
    parameter int W = 8,
    parameter int N = 4,
    localparam int S = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   s_data,
    input  logic [N-1:0]     s_valid,
    output logic [N-1:0]     s_ready,
    output logic [W+S-1:0]   m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    logic         load;
    logic         any;
    logic [S-1:0] g;
    logic [S-1:0] ptr;

    assign load = ~m_valid | m_ready;

    // Search starts at ptr and wraps explicitly, so N need not be a power of two.
    always_comb begin
        int unsigned  idx;
        logic [S-1:0] cand;
        g    = '0;
        any  = 1'b0;
        idx  = 0;
        cand = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr + k;
            if (idx >= N) idx = idx - N;
            cand = S'(idx);
            if (!any && s_valid[cand]) begin
                any = 1'b1;
                g   = cand;
            end
        end
    end

    // Gated by reset so no handshake can complete while the block is held in reset.
    always_comb begin
        s_ready = '0;
        if (rst && load && any) s_ready[g] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (load) begin
            if (any) begin
                m_valid <= 1'b1;
                m_data  <= {g, s_data[g*W +: W]};
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef ARBITRATE_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (load && any) begin
            ptr <= (g == S'(N - 1)) ? '0 : g + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

endmodule

// File: tb/tb_arbitrate.sv
// Directed self-checking bench for arbitrate (W=8, N=4); expectations follow ARBITRATE_ROUND_ROBIN_EN.
module tb_arbitrate;

    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 2;
`ifdef ARBITRATE_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   s_data;
    logic [N-1:0]     s_valid;
    logic [N-1:0]     s_ready;
    logic [W+S-1:0]   m_data;
    logic             m_valid;
    logic             m_ready;

    int total = 0;
    int bad   = 0;

    arbitrate #(.W(W), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] sel;
        logic [9:0] held;

        // Reset with busy random inputs
        rst     = 1'b0;
        m_ready = 1'b1;
        s_valid = 4'hF;
        s_data  = $urandom;
        step();
        s_data  = $urandom;
        step();
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_data",  32'(m_data),  32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h0);

        // Release reset away from an edge; single source on channel 2
        #2;
        rst     = 1'b1;
        s_valid = 4'b0100;
        s_data[23:16] = 8'hA5;
        #1;
        chk("first_s_ready", 32'(s_ready), 32'h4);
        step();
        chk("first_m_data",  32'(m_data),  32'h2A5);
        chk("first_m_valid", 32'(m_valid), 32'h1);

        // No source valid: m_valid drops, m_data holds
        s_valid = 4'b0000;
        step();
        chk("idle_m_valid", 32'(m_valid), 32'h0);
        chk("idle_m_data",  32'(m_data),  32'h2A5);

        // Pointer at 3 (round-robin): only channel 1 valid, wrap to it
        s_valid = 4'b0010;
        s_data[15:8] = 8'h11;
        #1;
        chk("wrap_s_ready", 32'(s_ready), 32'h2);
        step();
        chk("wrap_m_data", 32'(m_data), 32'h111);

        // Channels 0 and 2 valid: pointer now 2 picks channel 2; fixed priority picks 0
        s_valid = 4'b0101;
        s_data[7:0]   = 8'h20;
        s_data[23:16] = 8'h22;
        #1;
        chk("sparse_s_ready", 32'(s_ready), RR ? 32'h4 : 32'h1);
        step();
        chk("sparse_m_data", 32'(m_data), RR ? 32'h222 : 32'h020);

        // Channel 3 only, returns round-robin pointer to 0
        s_valid = 4'b1000;
        s_data[31:24] = 8'h33;
        step();
        chk("ch3_m_data", 32'(m_data), 32'h333);

        // All valid, full throughput for 8 cycles
        s_valid = 4'hF;
        for (int i = 0; i < N; i++) s_data[i*W +: W] = 8'(8'h40 + i);
        for (int i = 0; i < 8; i++) begin
            step();
            sel = RR ? 2'(i % N) : 2'd0;
            chk($sformatf("rr_%0d_m_data", i), 32'(m_data), 32'({sel, 8'(8'h40 + sel)}));
            chk($sformatf("rr_%0d_m_valid", i), 32'(m_valid), 32'h1);
        end

        // Backpressure for 5 cycles: output and pointer frozen, no ready
        held = RR ? 10'h343 : 10'h040;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_%0d_s_ready", i), 32'(s_ready), 32'h0);
            step();
            chk($sformatf("bp_%0d_m_data", i), 32'(m_data), 32'(held));
            chk($sformatf("bp_%0d_m_valid", i), 32'(m_valid), 32'h1);
        end
        m_ready = 1'b1;
        #1;
        chk("bp_release_s_ready", 32'(s_ready), 32'h1);
        step();
        chk("bp_next0_m_data", 32'(m_data), 32'h040);
        step();
        chk("bp_next1_m_data", 32'(m_data), RR ? 32'h141 : 32'h040);

        // Mid-transfer reset: output stalled, reset asserted between edges
        m_ready = 1'b0;
        step();
        chk("mid_pre_m_valid", 32'(m_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_m_valid", 32'(m_valid), 32'h0);
        chk("mid_m_data",  32'(m_data),  32'h0);
        chk("mid_s_ready", 32'(s_ready), 32'h0);
        #1;
        rst     = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("post_rst_s_ready", 32'(s_ready), 32'h1);
        step();
        chk("post_rst_m_data", 32'(m_data), 32'h040);
        step();
        chk("post_rst_next_m_data", 32'(m_data), RR ? 32'h141 : 32'h040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arbitrate.md
# arbitrate

N-to-1 arbitrating multiplexer that merges N independent valid/ready streams into one stream tagged with the index of the winning source. The output word is `{sel, dat}` with the channel index in the MSBs, the same packing the `demultiplex` stage consumes on its `s_` port. An `arbitrate`/`demultiplex` pair therefore forms a shared-link crossbar slice. Output is fully registered: one cycle latency, full throughput.

## Interface

- `W`, default 8: payload width per channel.
- `N`, default 4: number of input channels, N ≥ 2; `S = $clog2(N)`.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `s_data`  in  N*W  input payloads; channel i at `[i*W +: W]`.
- `s_valid`  in  N  per-channel valid.
- `s_ready`  out  N  per-channel ready; at most one bit set per cycle.
- `m_data`  out  W+S  `{sel, dat}`; `sel` = winning channel index.
- `m_valid`  out  1  output valid.
- `m_ready`  in  1  downstream ready.

## Operation

- State: output register (`m_valid`, `m_data`) and priority pointer `ptr` (S bits, range 0..N-1).
- `load = ~m_valid | m_ready`. The register accepts a new word only when `load` is high.
- Grant is combinational: among channels with `s_valid[i]` high, pick the first at or after `ptr` in ascending order, wrapping N-1 → 0. `g` = granted index, `any` = at least one valid.
- `s_ready[i] = load & any & (i == g)`. It never depends on `s_valid[i]` of another channel beyond the grant selection.
- On a clock edge with `load`:
  - if `any`: `m_valid ← 1`, `m_data ← {g, s_data[g*W +: W]}`, `ptr ← (g+1) mod N`. Wrap is explicit; N need not be a power of two.
  - else: `m_valid ← 0`, `m_data` holds, `ptr` holds.
- With `m_valid & ~m_ready`: `m_data`, `m_valid` and `ptr` hold, and all `s_ready` are 0.
- No sources valid: `m_valid` drops once the held word is consumed.
- Reset asserted at any time, including mid-transfer: `m_valid = 0`, `m_data = 0`, `ptr = 0` immediately. Words in flight are discarded; no partial state survives. Outputs are quiescent during reset.

## Timing

- Latency: a word granted at edge k is visible on `m_data`/`m_valid` after edge k. One cycle from `s_valid & s_ready` to `m_valid`.
- Throughput: one word per cycle while `m_ready` stays high and any source is valid.
- Combinational paths: `m_ready → s_ready` and `s_valid → s_ready`. No path from `s_*` to `m_*`.
- A source must hold `s_valid` and `s_data` until its `s_ready`. The block never grants a channel whose `s_valid` is low.
- Fairness in round-robin mode: with all N valid continuously, grants are exactly cyclic. No channel waits more than N-1 transfers.

## Configuration

- `ARBITRATE_ROUND_ROBIN_EN` defined: behaviour as above; `ptr` rotates after each transfer.
- Not defined: fixed priority, lowest index wins. `ptr` is not implemented and is treated as constant 0. Channel 0 can starve the others. All other behaviour and timing are unchanged.

## Test plan

Parameters for all cases: W=8, N=4; all cases run with the macro defined unless noted.

- Reset: hold `rst`=0 with random `s_*` and `m_ready`=1 → `m_valid`=0, `m_data`=0, `s_ready`=0. After release, `s_valid`=4'b0100 with `s_data[23:16]`=8'hA5 → next cycle `m_data`=10'h2A5.
- Round-robin: all `s_valid`=1, `m_ready`=1, 8 cycles → `sel` sequence 0,1,2,3,0,1,2,3, one word per cycle. Without the macro → 0,0,0,0,0,0,0,0.
- Backpressure: `m_ready`=0 for 5 cycles after the first grant → `m_data` stable and `s_ready`=0 throughout. No word is lost or duplicated when `m_ready` returns.
- Sparse / wrap: `ptr`=3, `s_valid`=4'b0010 → channel 1 granted, `ptr` becomes 2. Then `s_valid`=4'b0101 → channel 2 granted.
- Mid-transfer reset: assert `rst` while `m_valid`=1 and `m_ready`=0 → `m_valid` falls without waiting for a clock edge. The first grant after reset starts from channel 0.
- Loopback: connect to `demultiplex #(8,4)`, 256 random words per source, random stalls on every port → each sink receives its own source's words in order and unchanged. Completes within 10^6 cycles.
